axi_lite_rr_arbiter: RTL and testbench

N-to-1 AXI-Lite arbiter that shares one downstream AXI-Lite sink (typically an axi_lite_bridge feeding a CSR fabric) among NUM_SRC requesters.
- Write and read paths are arbitrated independently, each by its own round-robin scheduler.
- Each path allows exactly one outstanding transaction.
- Responses are routed back to the requester that owns the grant.

---
 rtl/axi_lite_arb_pkg.sv | 19 +
 rtl/rr_arbiter_core.sv | 28 ++
 rtl/axi_lite_rr_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_axi_lite_rr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arb_pkg.sv
// axi_lite_arb_pkg: shared FSM encodings and AXI response codes for the AXI-Lite arbiter
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core: picks the first active request strictly after the pointer, wrapping around
module rr_arbiter_core #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] gnt_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return IW'((s >= N) ? s - N : s);
    endfunction

    // scan from the farthest candidate back to ptr+1 so the nearest active request wins
    always_comb begin
        gnt_o = ptr_i;
        for (int k = N; k >= 1; k--)
            if (req_i[wrap(ptr_i, k)]) gnt_o = wrap(ptr_i, k);
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter: shares one AXI-Lite sink among NUM_SRC requesters with independent RR read/write paths
module axi_lite_rr_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SRC-1:0]                s_awvalid,
    output logic [NUM_SRC-1:0]                s_awready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [NUM_SRC*3-1:0]              s_awprot,
    input  logic [NUM_SRC-1:0]                s_wvalid,
    output logic [NUM_SRC-1:0]                s_wready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     s_wdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]   s_wstrb,
    output logic [NUM_SRC-1:0]                s_bvalid,
    input  logic [NUM_SRC-1:0]                s_bready,
    output logic [NUM_SRC*2-1:0]              s_bresp,
    input  logic [NUM_SRC-1:0]                s_arvalid,
    output logic [NUM_SRC-1:0]                s_arready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]     s_araddr,
    input  logic [NUM_SRC*3-1:0]              s_arprot,
    output logic [NUM_SRC-1:0]                s_rvalid,
    input  logic [NUM_SRC-1:0]                s_rready,
    output logic [NUM_SRC*DATA_WIDTH-1:0]     s_rdata,
    output logic [NUM_SRC*2-1:0]              s_rresp,
    output logic                              m_awvalid,
    input  logic                              m_awready,
    output logic [ADDR_WIDTH-1:0]             m_awaddr,
    output logic [2:0]                        m_awprot,
    output logic                              m_wvalid,
    input  logic                              m_wready,
    output logic [DATA_WIDTH-1:0]             m_wdata,
    output logic [DATA_WIDTH/8-1:0]           m_wstrb,
    input  logic                              m_bvalid,
    output logic                              m_bready,
    input  logic [1:0]                        m_bresp,
    output logic                              m_arvalid,
    input  logic                              m_arready,
    output logic [ADDR_WIDTH-1:0]             m_araddr,
    output logic [2:0]                        m_arprot,
    input  logic                              m_rvalid,
    output logic                              m_rready,
    input  logic [DATA_WIDTH-1:0]             m_rdata,
    input  logic [1:0]                        m_rresp,
    output logic [$clog2(NUM_SRC)-1:0]        wr_gnt_id,
    output logic [$clog2(NUM_SRC)-1:0]        rd_gnt_id,
    output logic                              wr_busy,
    output logic                              rd_busy
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int SW = DATA_WIDTH / 8;

    wr_state_t     wr_state_q, wr_state_d;
    rd_state_t     rd_state_q, rd_state_d;
    logic [IW-1:0] wr_gnt_q, wr_gnt_d;
    logic [IW-1:0] rd_gnt_q, rd_gnt_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [IW-1:0] wr_arb_gnt, rd_arb_gnt;
    logic          wr_arb_valid, rd_arb_valid;

    rr_arbiter_core #(.N(NUM_SRC)) u_wr_arb (
        .req_i   (s_awvalid | s_wvalid),
        .ptr_i   (wr_gnt_q),
        .gnt_o   (wr_arb_gnt),
        .valid_o (wr_arb_valid)
    );

    rr_arbiter_core #(.N(NUM_SRC)) u_rd_arb (
        .req_i   (s_arvalid),
        .ptr_i   (rd_gnt_q),
        .gnt_o   (rd_arb_gnt),
        .valid_o (rd_arb_valid)
    );

    // write path state; the grant index doubles as the round-robin pointer while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_gnt_q   <= IW'(NUM_SRC - 1);
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_gnt_q   <= wr_gnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // write next state: grant, collect AW and W in any order, then wait for B
    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_arb_valid) begin
                    wr_state_d = W_REQ;
                    wr_gnt_d   = wr_arb_gnt;
                end
            end
            W_REQ: begin
                aw_done_d = aw_done_q | (m_awvalid & m_awready);
                w_done_d  = w_done_q | (m_wvalid & m_wready);
                if (aw_done_d & w_done_d) begin
                    wr_state_d = W_RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            W_RESP: begin
                if (m_bvalid & m_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // write outputs: only the granted requester is connected downstream
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_awaddr  = s_awaddr[wr_gnt_q*ADDR_WIDTH +: ADDR_WIDTH];
        m_awprot  = s_awprot[wr_gnt_q*3 +: 3];
        m_wdata   = s_wdata[wr_gnt_q*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb   = s_wstrb[wr_gnt_q*SW +: SW];
        if (wr_state_q == W_REQ) begin
            m_awvalid           = s_awvalid[wr_gnt_q] & ~aw_done_q;
            m_wvalid            = s_wvalid[wr_gnt_q] & ~w_done_q;
            s_awready[wr_gnt_q] = m_awready & ~aw_done_q;
            s_wready[wr_gnt_q]  = m_wready & ~w_done_q;
        end
        if (wr_state_q == W_RESP) begin
            m_bready           = s_bready[wr_gnt_q];
            s_bvalid[wr_gnt_q] = m_bvalid;
        end
    end

    // read path state, same pointer scheme as the write path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_gnt_q   <= IW'(NUM_SRC - 1);
        end else begin
            rd_state_q <= rd_state_d;
            rd_gnt_q   <= rd_gnt_d;
        end
    end

    // read next state: grant, pass one AR, then wait for R
    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_arb_valid) begin
                    rd_state_d = R_ADDR;
                    rd_gnt_d   = rd_arb_gnt;
                end
            end
            R_ADDR: begin
                if (m_arvalid & m_arready) rd_state_d = R_RESP;
            end
            R_RESP: begin
                if (m_rvalid & m_rready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // read outputs: AR and R handshakes are steered to the granted requester only
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_araddr  = s_araddr[rd_gnt_q*ADDR_WIDTH +: ADDR_WIDTH];
        m_arprot  = s_arprot[rd_gnt_q*3 +: 3];
        if (rd_state_q == R_ADDR) begin
            m_arvalid           = s_arvalid[rd_gnt_q];
            s_arready[rd_gnt_q] = m_arready;
        end
        if (rd_state_q == R_RESP) begin
            m_rready           = s_rready[rd_gnt_q];
            s_rvalid[rd_gnt_q] = m_rvalid;
        end
    end

    assign s_bresp   = {NUM_SRC{m_bresp}};
    assign s_rdata   = {NUM_SRC{m_rdata}};
    assign s_rresp   = {NUM_SRC{m_rresp}};
    assign wr_gnt_id = wr_gnt_q;
    assign rd_gnt_id = rd_gnt_q;
    assign wr_busy   = (wr_state_q != W_IDLE);
    assign rd_busy   = (rd_state_q != R_IDLE);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// tb_axi_lite_rr_arbiter: directed scoreboard bench for the AXI-Lite round-robin arbiter
module tb_axi_lite_rr_arbiter;
    import axi_lite_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0] s_awaddr, s_araddr;
    logic [N*3-1:0] s_awprot, s_arprot;
    logic [N*DW-1:0] s_wdata, s_rdata;
    logic [N*SW-1:0] s_wstrb;
    logic [N*2-1:0] s_bresp, s_rresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0] m_awprot, m_arprot;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [1:0] m_bresp, m_rresp;
    logic [IW-1:0] wr_gnt_id, rd_gnt_id;
    logic wr_busy, rd_busy;

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;
    int ar_cnt = 0;
    int aw0, w0;
    logic [95:0] q_aw[$];
    logic [95:0] q_w[$];
    logic [95:0] q_ar[$];

    axi_lite_rr_arbiter #(.NUM_SRC(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .wr_gnt_id(wr_gnt_id), .rd_gnt_id(rd_gnt_id), .wr_busy(wr_busy), .rd_busy(rd_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_aw(input int s, input logic [AW-1:0] a);
        s_awaddr[s*AW +: AW] = a;
        s_awprot[s*3 +: 3]   = 3'(s + 1);
        s_awvalid[s]         = 1'b1;
        q_aw.push_back(96'({3'(s + 1), a}));
    endtask

    task automatic req_w(input int s, input logic [DW-1:0] d);
        s_wdata[s*DW +: DW] = d;
        s_wstrb[s*SW +: SW] = 8'(8'hA0 + s);
        s_wvalid[s]         = 1'b1;
        q_w.push_back(96'({8'(8'hA0 + s), d}));
    endtask

    task automatic req_ar(input int s, input logic [AW-1:0] a);
        s_araddr[s*AW +: AW] = a;
        s_arprot[s*3 +: 3]   = 3'(s + 4);
        s_arvalid[s]         = 1'b1;
        q_ar.push_back(96'({3'(s + 4), a}));
    endtask

    // requester side of the AW/W phase: drop each valid after its own handshake
    task automatic wr_data_phase(input int s);
        logic aw_d, w_d, a, w;
        aw_d = 1'b0;
        w_d  = 1'b0;
        for (int i = 0; i < 30 && !(aw_d && w_d); i++) begin
            @(negedge clk);
            a = s_awvalid[s] & s_awready[s];
            w = s_wvalid[s] & s_wready[s];
            tick();
            if (a) begin s_awvalid[s] = 1'b0; aw_d = 1'b1; end
            if (w) begin s_wvalid[s] = 1'b0; w_d = 1'b1; end
        end
        chk("wr_data_phase_done", 96'({aw_d, w_d}), 96'(2'b11));
    endtask

    task automatic rd_phase(input int s, input bit hold);
        logic a, got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            a = s_arvalid[s] & s_arready[s];
            tick();
            if (a) begin
                got = 1'b1;
                if (!hold) s_arvalid[s] = 1'b0;
            end
        end
        chk("rd_phase_done", 96'(got), 96'(1'b1));
    endtask

    task automatic give_b(input int s, input logic [1:0] resp);
        m_bvalid    = 1'b1;
        m_bresp     = resp;
        s_bready[s] = 1'b1;
        #1;
        chk("b_owner", 96'(s_bvalid), 96'(3'b001 << s));
        chk("b_resp", 96'(s_bresp[s*2 +: 2]), 96'(resp));
        chk("b_ready", 96'(m_bready), 96'(1'b1));
        tick();
        m_bvalid    = 1'b0;
        s_bready[s] = 1'b0;
    endtask

    task automatic give_r(input int s, input logic [DW-1:0] d);
        m_rvalid    = 1'b1;
        m_rdata     = d;
        m_rresp     = AXI_RESP_OKAY;
        s_rready[s] = 1'b1;
        #1;
        chk("r_owner", 96'(s_rvalid), 96'(3'b001 << s));
        chk("r_data", 96'(s_rdata[s*DW +: DW]), 96'(d));
        chk("r_ready", 96'(m_rready), 96'(1'b1));
        tick();
        m_rvalid    = 1'b0;
        s_rready[s] = 1'b0;
    endtask

    // downstream scoreboard: every handshake must match the next expected beat in order
    always @(negedge clk) begin : mon
        logic [95:0] e;
        if (rst_n) begin
            if (m_awvalid && m_awready) begin
                aw_cnt++;
                e = 'x;
                if (q_aw.size() > 0) e = q_aw.pop_front();
                chk("aw_beat", 96'({m_awprot, m_awaddr}), e);
            end
            if (m_wvalid && m_wready) begin
                w_cnt++;
                e = 'x;
                if (q_w.size() > 0) e = q_w.pop_front();
                chk("w_beat", 96'({m_wstrb, m_wdata}), e);
            end
            if (m_arvalid && m_arready) begin
                ar_cnt++;
                e = 'x;
                if (q_ar.size() > 0) e = q_ar.pop_front();
                chk("ar_beat", 96'({m_arprot, m_araddr}), e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} = '0;
        {s_awaddr, s_araddr, s_awprot, s_arprot, s_wdata, s_wstrb} = '0;
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        m_bresp = '0; m_rresp = '0; m_rdata = '0;
        s_awvalid = 3'b010; s_arvalid = 3'b100; m_awready = 1'b1; m_arready = 1'b1;
        repeat (3) tick();
        chk("rst_m_awvalid", 96'(m_awvalid), 96'(0));
        chk("rst_m_wvalid", 96'(m_wvalid), 96'(0));
        chk("rst_m_arvalid", 96'(m_arvalid), 96'(0));
        chk("rst_m_bready", 96'(m_bready), 96'(0));
        chk("rst_m_rready", 96'(m_rready), 96'(0));
        chk("rst_s_readys", 96'({s_awready, s_wready, s_arready}), 96'(0));
        chk("rst_s_valids", 96'({s_bvalid, s_rvalid}), 96'(0));
        chk("rst_wr_gnt", 96'(wr_gnt_id), 96'(N - 1));
        chk("rst_rd_gnt", 96'(rd_gnt_id), 96'(N - 1));
        chk("rst_busy", 96'({wr_busy, rd_busy}), 96'(0));
        s_awvalid = '0; s_arvalid = '0; m_awready = 1'b0; m_arready = 1'b0;
        rst_n = 1'b1;
        tick();

        // back-to-back writes from src0
        m_awready = 1'b1; m_wready = 1'b1;
        req_aw(0, 20'h100); req_w(0, 64'hDEAD);
        #1;
        chk("t1_no_valid_grant_cycle", 96'({m_awvalid, m_wvalid, wr_busy}), 96'(0));
        tick();
        chk("t1_gnt", 96'(wr_gnt_id), 96'(0));
        chk("t1_m_valids", 96'({m_awvalid, m_wvalid}), 96'(2'b11));
        chk("t1_s_readys", 96'({s_awready, s_wready}), 96'(6'b001_001));
        wr_data_phase(0);
        m_bvalid = 1'b1; m_bresp = AXI_RESP_OKAY; s_bready[0] = 1'b1;
        req_aw(0, 20'h108); req_w(0, 64'hBEEF0);
        #1;
        chk("t1_b_owner", 96'({s_bvalid, m_bready}), 96'(4'b0011));
        chk("t1_no_aw_in_resp", 96'({m_awvalid, s_awready}), 96'(0));
        tick();
        m_bvalid = 1'b0; s_bready[0] = 1'b0;
        #1;
        chk("t1_idle_after_b", 96'({wr_busy, m_awvalid}), 96'(0));
        tick();
        chk("t1_regrant", 96'({wr_busy, wr_gnt_id, m_awvalid}), 96'({1'b1, 2'd0, 1'b1}));
        wr_data_phase(0);
        give_b(0, AXI_RESP_OKAY);

        // round-robin reads with all three requesters holding AR
        m_arready = 1'b1;
        req_ar(0, 20'h10); req_ar(1, 20'h20); req_ar(2, 20'h30);
        q_ar.push_back(96'({3'(4), 20'h10}));
        rd_phase(0, 1'b1); give_r(0, 64'hA0A0);
        rd_phase(1, 1'b1); give_r(1, 64'hA1A1);
        rd_phase(2, 1'b1); give_r(2, 64'hA2A2);
        rd_phase(0, 1'b1);
        s_arvalid = '0;
        give_r(0, 64'hA3A3);
        chk("t2_ar_count", 96'(ar_cnt), 96'(4));

        // split AW/W from src1 with W early and AW backpressured
        m_awready = 1'b0; m_wready = 1'b1;
        aw0 = aw_cnt; w0 = w_cnt;
        req_w(1, 64'hBEEF);
        tick();
        chk("t3_gnt", 96'(wr_gnt_id), 96'(1));
        chk("t3_w_only", 96'({m_awvalid, m_wvalid}), 96'(2'b01));
        tick();
        s_wvalid[1] = 1'b0;
        #1;
        chk("t3_w_done", 96'({m_wvalid, s_wready}), 96'(0));
        tick();
        tick();
        req_aw(1, 20'h200);
        #1;
        chk("t3_aw_stall", 96'({m_awvalid, s_awready}), 96'({1'b1, 3'b000}));
        tick();
        chk("t3_aw_stall2", 96'({m_awvalid, m_wvalid, wr_busy}), 96'(3'b101));
        m_awready = 1'b1;
        #1;
        chk("t3_aw_ready", 96'(s_awready), 96'(3'b010));
        tick();
        s_awvalid[1] = 1'b0;
        chk("t3_single_beats", 96'({aw_cnt - aw0, w_cnt - w0}), 96'({32'd1, 32'd1}));
        give_b(1, AXI_RESP_SLVERR);

        // concurrent write (src0) and read (src1)
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        req_aw(0, 20'h300); req_w(0, 64'h1234); req_ar(1, 20'h400);
        tick();
        chk("t4_all_valid", 96'({m_awvalid, m_wvalid, m_arvalid}), 96'(3'b111));
        chk("t4_busy", 96'({wr_busy, rd_busy}), 96'(2'b11));
        chk("t4_gnts", 96'({wr_gnt_id, rd_gnt_id}), 96'({2'd0, 2'd1}));
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        tick();
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0; s_arvalid[1] = 1'b0;
        m_bvalid = 1'b1; m_bresp = AXI_RESP_OKAY; s_bready[0] = 1'b1;
        m_rvalid = 1'b1; m_rdata = 64'h5151; s_rready[1] = 1'b1;
        #1;
        chk("t4_both_resp", 96'({s_bvalid, s_rvalid}), 96'(6'b001_010));
        chk("t4_rdata", 96'(s_rdata[DW +: DW]), 96'(64'h5151));
        tick();
        m_bvalid = 1'b0; s_bready[0] = 1'b0; m_rvalid = 1'b0; s_rready[1] = 1'b0;
        #1;
        chk("t4_idle", 96'({wr_busy, rd_busy}), 96'(0));

        // B backpressure from src2 holds off a src0 write
        req_aw(2, 20'h500); req_w(2, 64'h55);
        tick();
        chk("t5_gnt2", 96'(wr_gnt_id), 96'(2));
        wr_data_phase(2);
        m_bvalid = 1'b1; m_bresp = AXI_RESP_OKAY;
        req_aw(0, 20'h600); req_w(0, 64'h66);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_hold", 96'({m_bready, s_bvalid, m_awvalid, wr_gnt_id}), 96'({1'b0, 3'b100, 1'b0, 2'd2}));
            tick();
        end
        s_bready[2] = 1'b1;
        #1;
        chk("t5_bready", 96'(m_bready), 96'(1));
        tick();
        m_bvalid = 1'b0; s_bready[2] = 1'b0;
        #1;
        chk("t5_idle", 96'({wr_busy, m_awvalid}), 96'(0));
        tick();
        chk("t5_src0_gnt", 96'({wr_gnt_id, m_awvalid}), 96'({2'd0, 1'b1}));
        wr_data_phase(0);
        give_b(0, AXI_RESP_OKAY);

        // reset while src1 is in the middle of its write
        m_awready = 1'b1; m_wready = 1'b0;
        req_aw(1, 20'h700);
        s_wdata[DW +: DW] = 64'h77; s_wvalid[1] = 1'b1;
        tick();
        chk("t6_gnt1", 96'(wr_gnt_id), 96'(1));
        tick();
        s_awvalid[1] = 1'b0;
        #1;
        chk("t6_aw_done", 96'({m_awvalid, m_wvalid}), 96'(2'b01));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", 96'({m_awvalid, m_wvalid, s_wready, s_awready, wr_busy}), 96'(0));
        chk("t6_rst_gnt", 96'(wr_gnt_id), 96'(N - 1));
        s_wvalid = '0;
        tick();
        rst_n = 1'b1;
        m_wready = 1'b1;
        req_aw(0, 20'h800); req_w(0, 64'h88);
        tick();
        req_aw(1, 20'h900); req_w(1, 64'h99);
        chk("t6_src0_first", 96'(wr_gnt_id), 96'(0));
        wr_data_phase(0);
        give_b(0, AXI_RESP_OKAY);
        tick();
        chk("t6_src1_next", 96'(wr_gnt_id), 96'(1));
        wr_data_phase(1);
        give_b(1, AXI_RESP_OKAY);

        chk("queues_drained", 96'(q_aw.size() + q_w.size() + q_ar.size()), 96'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
